// File: rtl/si53xx_spi_responder_pkg.sv
// Shared definitions for the Si53xx-style SPI register interface.
// Holds the 3-bit command opcodes carried in bits [7:5] of the command byte,
// the responder FSM state encoding, and small opcode-decode helpers used by
// both the initiator side and the responder.
package si53xx_spi_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WDATA = 3'd3,
    ST_RDATA = 3'd4
  } state_e;

  localparam logic [2:0] OP_SET_ADDR  = 3'b000;
  localparam logic [2:0] OP_WRITE     = 3'b010;
  localparam logic [2:0] OP_WRITE_INC = 3'b011;
  localparam logic [2:0] OP_READ      = 3'b100;
  localparam logic [2:0] OP_READ_INC  = 3'b101;

  // True for the auto-increment flavours of write and read.
  function automatic logic op_is_incr(input logic [2:0] op);
    case (op)
      OP_WRITE_INC, OP_READ_INC: op_is_incr = 1'b1;
      default:                   op_is_incr = 1'b0;
    endcase
  endfunction

  // State entered once the command byte is complete; unknown opcodes park
  // the FSM in IDLE so the rest of the transaction is ignored.
  function automatic state_e op_next_state(input logic [2:0] op);
    case (op)
      OP_SET_ADDR:            op_next_state = ST_ADDR;
      OP_WRITE, OP_WRITE_INC: op_next_state = ST_WDATA;
      OP_READ, OP_READ_INC:   op_next_state = ST_RDATA;
      default:                op_next_state = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/si53xx_sync_edge.sv
// Two-flop synchronizer with edge detection for an asynchronous level input.
// Ports:
//   clk, reset : block clock, asynchronous active-high reset
//   d          : asynchronous input level
//   q          : synchronized level
//   rise, fall : one-clk pulses on synchronized rising / falling edges
// IDLE_LVL is the level all flops take in reset, so no edge is reported
// while the line sits at its idle level after reset.
module si53xx_sync_edge #(
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronizer pair plus one history flop for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r <= IDLE_LVL;
      sync_r <= IDLE_LVL;
      prev_r <= IDLE_LVL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign q    = sync_r;
  assign rise = sync_r & ~prev_r;
  assign fall = ~sync_r & prev_r;

endmodule

// File: rtl/si53xx_spi_responder.sv
// SPI (mode 0) responder exposing a 256 x 8 register file.
// Ports:
//   clk, reset        : block clock, asynchronous active-high reset
//   nCS, sclk, sdi    : SPI inputs, asynchronous to clk
//   sdo, sdo_oe       : SPI read data and its output enable
//   host_addr/rdata   : local combinational read port of the register file
//   wr_strobe/addr/data : one-clk notification of every SPI register write
// Transaction: command byte (opcode in [7:5]) followed by an address byte
// (set-address) or data bytes (write / read). The pointer survives nCS.
module si53xx_spi_responder
  import si53xx_spi_responder_pkg::*;
#(
  parameter int         SCLK_MIN_DIV = 32'sd8,
  parameter logic [7:0] RESET_VAL    = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nCS,
  input  logic       sclk,
  input  logic       sdi,
  output logic       sdo,
  output logic       sdo_oe,
  input  logic [7:0] host_addr,
  output logic [7:0] host_rdata,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  // After reset the nCS synchronizer holds its idle level until it has
  // flushed; only trust a "high" reading once half an sclk period has passed.
  localparam int SETTLE_INT = (SCLK_MIN_DIV / 32'sd2 > 32'sd3) ?
                              (SCLK_MIN_DIV / 32'sd2) : 32'sd3;
  localparam logic [7:0] SETTLE_CYC = 8'(SETTLE_INT);

  logic       ncs_q_s, ncs_rise_s, ncs_fall_s;
  logic       sclk_q_s, sclk_rise_s, sclk_fall_s;
  logic       sdi_meta_r, sdi_q_r;
  logic [7:0] settle_r;
  logic       armed_r;
  state_e     state_r, state_next_s;
  logic [2:0] bit_cnt_r;
  logic [7:0] rx_r, rx_byte_s;
  logic       byte_done_s;
  logic [7:0] ptr_r, ptr_next_s, ptr_inc_s;
  logic       incr_r, incr_next_s;
  logic [7:0] tx_r, tx_next_s;
  logic       we_s;
  logic       sdo_r, sdo_oe_r;
  logic       wr_strobe_r;
  logic [7:0] wr_addr_r, wr_data_r;
  logic [7:0] regs_r [256];

  si53xx_sync_edge #(.IDLE_LVL(1'b1)) u_sync_ncs (
    .clk(clk), .reset(reset), .d(nCS),
    .q(ncs_q_s), .rise(ncs_rise_s), .fall(ncs_fall_s)
  );

  si53xx_sync_edge #(.IDLE_LVL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d(sclk),
    .q(sclk_q_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  // sdi uses the same two-flop depth as sclk so data and edge stay aligned
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sdi_meta_r <= 1'b0;
      sdi_q_r    <= 1'b0;
    end else begin
      sdi_meta_r <= sdi;
      sdi_q_r    <= sdi_meta_r;
    end
  end

  // Arm the FSM only once nCS is genuinely seen high after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_r <= 8'd0;
      armed_r  <= 1'b0;
    end else begin
      if (settle_r != SETTLE_CYC) begin
        settle_r <= settle_r + 8'd1;
      end
      if (ncs_rise_s || (ncs_q_s && (settle_r == SETTLE_CYC))) begin
        armed_r <= 1'b1;
      end
    end
  end

  assign rx_byte_s   = {rx_r[6:0], sdi_q_r};
  assign byte_done_s = sclk_rise_s & ~ncs_q_s & (bit_cnt_r == 3'd7);
  assign ptr_inc_s   = ptr_r + 8'd1;

  // Next-state, pointer, transmit-byte and write-request decode
  always_comb begin
    state_next_s = state_r;
    ptr_next_s   = ptr_r;
    incr_next_s  = incr_r;
    tx_next_s    = tx_r;
    we_s         = 1'b0;
    if (ncs_q_s) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ncs_fall_s && armed_r) begin
            state_next_s = ST_CMD;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_CMD: begin
          if (byte_done_s) begin
            state_next_s = op_next_state(rx_byte_s[7:5]);
            incr_next_s  = op_is_incr(rx_byte_s[7:5]);
            tx_next_s    = regs_r[ptr_r];
          end else begin
            state_next_s = ST_CMD;
          end
        end
        ST_ADDR: begin
          if (byte_done_s) begin
            ptr_next_s   = rx_byte_s;
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_ADDR;
          end
        end
        ST_WDATA: begin
          if (byte_done_s) begin
            we_s = 1'b1;
            if (incr_r) begin
              ptr_next_s = ptr_inc_s;
            end else begin
              state_next_s = ST_IDLE;
            end
          end else begin
            state_next_s = ST_WDATA;
          end
        end
        ST_RDATA: begin
          // The falling edge right after a (re)load is skipped so the MSB
          // stays on sdo for the next rising sclk.
          if (byte_done_s) begin
            if (incr_r) begin
              ptr_next_s = ptr_inc_s;
              tx_next_s  = regs_r[ptr_inc_s];
            end else begin
              tx_next_s = regs_r[ptr_r];
            end
          end else if (sclk_fall_s && (bit_cnt_r != 3'd0)) begin
            tx_next_s = {tx_r[6:0], 1'b0};
          end else begin
            tx_next_s = tx_r;
          end
        end
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // FSM state, bit counter, shift registers, pointer and SPI outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      rx_r      <= 8'h00;
      ptr_r     <= 8'h00;
      incr_r    <= 1'b0;
      tx_r      <= 8'h00;
      sdo_r     <= 1'b0;
      sdo_oe_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ptr_r   <= ptr_next_s;
      incr_r  <= incr_next_s;
      tx_r    <= tx_next_s;
      if (ncs_q_s) begin
        bit_cnt_r <= 3'd0;
      end else if (sclk_rise_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
        rx_r      <= rx_byte_s;
      end
      sdo_oe_r <= (state_next_s == ST_RDATA);
      sdo_r    <= (state_next_s == ST_RDATA) ? tx_next_s[7] : 1'b0;
    end
  end

  // Register file and the write notification outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_r      <= '{default: RESET_VAL};
      wr_strobe_r <= 1'b0;
      wr_addr_r   <= 8'h00;
      wr_data_r   <= 8'h00;
    end else begin
      wr_strobe_r <= we_s;
      if (we_s) begin
        regs_r[ptr_r] <= rx_byte_s;
        wr_addr_r     <= ptr_r;
        wr_data_r     <= rx_byte_s;
      end
    end
  end

  assign host_rdata = regs_r[host_addr];
  assign sdo        = sdo_r;
  assign sdo_oe     = sdo_oe_r;
  assign wr_strobe  = wr_strobe_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;

  // sclk level itself is only used through its edges
  logic unused_s;
  assign unused_s = sclk_q_s;

endmodule

// File: doc/si53xx_spi_responder.md
SI53XX_SPI_RESPONDER -- requirements
Module: si53xx_spi_responder

Interface
REQ-001 Parameter SCLK_MIN_DIV, default 8: minimum sclk period in clk cycles that the block SHALL tolerate.
REQ-002 Parameter RESET_VAL, default 8'h00: reset value of every register-file entry.
REQ-003 clk  input  1  the single block clock; all logic SHALL be synchronous to it.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 nCS  input  1  chip select from the SPI initiator, active-low, asynchronous to clk.
REQ-006 sclk  input  1  SPI clock, mode 0, idle low, asynchronous to clk.
REQ-007 sdi  input  1  serial data from the initiator, MSB first.
REQ-008 sdo  output  1  serial read data to the initiator, MSB first.
REQ-009 sdo_oe  output  1  sdo output enable; high only while read data is being shifted out.
REQ-010 host_addr  input  8  local register-file read address.
REQ-011 host_rdata  output  8  register-file content at host_addr, combinational.
REQ-012 wr_strobe  output  1  one-clk pulse for each SPI register write.
REQ-013 wr_addr  output  8  address of the SPI write; valid while wr_strobe is high.
REQ-014 wr_data  output  8  data of the SPI write; valid while wr_strobe is high.

Function
REQ-015 nCS, sclk and sdi SHALL each pass through a 2-flop synchronizer; sclk edges SHALL be detected from the synchronized value.
REQ-016 A rising sclk edge with nCS low SHALL shift sdi into the receive shift register, MSB first.
REQ-017 States: IDLE, CMD, ADDR, WDATA, RDATA; nCS high SHALL force IDLE and clear the bit counter within 3 clk cycles.
REQ-018 IDLE SHALL move to CMD on synchronized nCS falling.
REQ-019 When CMD completes its 8th bit, decode SHALL use bits[7:5] only: 000 -> ADDR; 010 -> WDATA; 011 -> WDATA with increment; 100 -> RDATA; 101 -> RDATA with increment; any other value -> IDLE, and all further bits are ignored until nCS rises.
REQ-020 ADDR, after 8 bits, SHALL load the address pointer (8 bits) and then wait for nCS high.
REQ-021 WDATA, after 8 bits, SHALL write the byte to register[pointer] and pulse wr_strobe for 1 clk with wr_addr=pointer and wr_data=byte.
REQ-022 In increment mode, WDATA SHALL then increment the pointer (wrapping 8'hFF->8'h00) and accept further bytes until nCS high; in non-increment mode, further bytes SHALL be ignored.
REQ-023 RDATA SHALL load register[pointer] into the transmit shift register on the clk following the 8th command bit.
REQ-024 In RDATA, sdo_oe SHALL be high, and sdo SHALL present the MSB before the next rising sclk edge and update on each falling sclk edge.
REQ-025 In RDATA increment mode, the pointer SHALL increment (with wrap) after each 8 bits and the next byte SHALL be reloaded without gap; in non-increment mode, the same register SHALL be resent.
REQ-026 The address pointer SHALL persist across transactions; only reset clears it.
REQ-027 A write coinciding with a host_rdata read of the same address SHALL return the old value that cycle and the new value the next cycle.
REQ-028 nCS rising mid-byte SHALL discard the partial byte with no write and no pointer change.
REQ-029 sdo SHALL be 0 whenever sdo_oe is low.
REQ-030 Correct operation SHALL be guaranteed for sclk high and low times each of at least SCLK_MIN_DIV/2 clk cycles.

Reset
REQ-031 Reset SHALL force the following values: state IDLE, pointer 8'h00, all registers RESET_VAL, sdo 0, sdo_oe 0, wr_strobe 0, wr_addr 8'h00, wr_data 8'h00, synchronizers to idle levels (nCS 1, sclk 0).
REQ-032 Reset asserted mid-transaction SHALL abort the transaction with no write.
REQ-033 After release, the block SHALL ignore activity until nCS is seen high.

Structure
REQ-034 A shared package SHALL hold the command opcodes (3'b000, 3'b010, 3'b011, 3'b100, 3'b101) and the state encoding; the master and responder SHALL both use it.
REQ-035 A sub-module si53xx_sync_edge SHALL contain the 2-flop synchronizer and edge detector, instantiated for sclk and nCS.

Verification
REQ-036 Set-addr 0x00,0x2A then write 0x40,0x5C -> one wr_strobe with wr_addr=0x2A and wr_data=0x5C, and host_rdata@0x2A=0x5C.
REQ-037 Master-style opcodes 0x4B and 0x8D -> decoded as write and read.
REQ-038 Read 0x80 after the above -> sdo_oe high for 8 bits and shifted byte 0x5C.
REQ-039 Addr 0xFE, then 0x60 followed by 0x11,0x22,0x33 -> registers 0xFE=0x11, 0xFF=0x22, 0x00=0x33, and the pointer wraps.
REQ-040 Write 0x40 aborted by nCS high after 5 data bits -> no wr_strobe and the register unchanged.
REQ-041 Reset pulse mid-read -> sdo_oe=0 and pointer=0x00 immediately, and a subsequent read returns RESET_VAL.
